// File: rtl/axis_rx_sink.sv
// AXI-Stream receive endpoint: programmable backpressure, frame reassembly and master-side protocol checks.
// Defining AXIS_RX_SINK_CHECKSUM_EN adds frame_xsum, the XOR of all data beats of the completed frame.

module axis_rx_sink #(
    parameter int          T_DATA_WIDTH = 8,
    parameter int          T_ID_WIDTH   = 8,
    parameter int          T_USER_WIDTH = 8,
    parameter int          LEN_WIDTH    = 16,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [T_ID_WIDTH-1:0]   s_id,
    input  logic [T_DATA_WIDTH-1:0] s_data,
    input  logic [T_USER_WIDTH-1:0] s_user,
    input  logic                    s_last,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [1:0]              bp_mode,
    input  logic [7:0]              bp_period,
    output logic                    frame_done,
    output logic [LEN_WIDTH-1:0]    frame_len,
    output logic [T_ID_WIDTH-1:0]   frame_id,
    output logic [T_USER_WIDTH-1:0] frame_user,
`ifdef AXIS_RX_SINK_CHECKSUM_EN
    output logic [T_DATA_WIDTH-1:0] frame_xsum,
`endif
    output logic [31:0]             frame_cnt,
    output logic [31:0]             beat_cnt,
    output logic                    err_vld_drop,
    output logic                    err_stable,
    output logic                    err_id,
    output logic                    err_len_ovf,
    input  logic                    err_clr,
    output logic                    o_dbg_state
);

    // Handshake: a beat transfers on a rising clk edge where s_valid and s_ready are both high.
    // s_ready is registered and may fall without a transfer; the master must hold valid and payload while stalled.

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_IN_FRAME = 1'b1
    } state_t;

    localparam logic [LEN_WIDTH-1:0] LEN_MAX = '1;
    localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

    state_t                  r_state;
    state_t                  w_state_nxt;

    logic [15:0]             r_lfsr;
    logic                    w_lfsr_fb;
    logic [7:0]              r_per_cnt;
    logic [7:0]              w_per_nxt;
    logic                    r_ready;
    logic                    w_ready_nxt;
    logic                    w_hs;

    logic [LEN_WIDTH-1:0]    r_len;
    logic [LEN_WIDTH-1:0]    w_len_inc;
    logic [LEN_WIDTH-1:0]    w_len_nxt;
    logic [T_ID_WIDTH-1:0]   r_id_cap;
    logic                    w_complete;
    logic [LEN_WIDTH-1:0]    w_cpl_len;
    logic [T_ID_WIDTH-1:0]   w_cpl_id;
    logic                    w_id_err;
    logic                    w_ovf_err;

    logic                    r_done;
    logic [LEN_WIDTH-1:0]    r_frame_len;
    logic [T_ID_WIDTH-1:0]   r_frame_id;
    logic [T_USER_WIDTH-1:0] r_frame_user;
    logic [31:0]             r_frame_cnt;
    logic [31:0]             r_beat_cnt;

    logic                    r_chk_en;
    logic                    r_stall;
    logic [T_ID_WIDTH-1:0]   r_snap_id;
    logic [T_DATA_WIDTH-1:0] r_snap_data;
    logic [T_USER_WIDTH-1:0] r_snap_user;
    logic                    r_snap_last;
    logic                    w_stall_chk;
    logic                    w_vld_drop_err;
    logic                    w_stable_err;

    logic                    r_err_vld_drop;
    logic                    r_err_stable;
    logic                    r_err_id;
    logic                    r_err_len_ovf;

    assign w_hs      = s_valid & r_ready;
    assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

    // Backpressure pattern for the next cycle; the period counter only runs in mode 3.
    always_comb begin
        w_ready_nxt = 1'b0;
        w_per_nxt   = 8'd0;
        case (bp_mode)
            2'd0: w_ready_nxt = 1'b1;
            2'd1: w_ready_nxt = r_lfsr[0] | r_lfsr[1];
            2'd2: w_ready_nxt = 1'b0;
            default: begin
                w_ready_nxt = (r_per_cnt == bp_period);
                w_per_nxt   = (r_per_cnt == bp_period) ? 8'd0 : r_per_cnt + 8'd1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_len_inc   = (r_len == LEN_MAX) ? LEN_MAX : r_len + LEN_ONE;
        w_len_nxt   = r_len;
        w_complete  = 1'b0;
        w_cpl_len   = r_len;
        w_cpl_id    = r_id_cap;
        w_id_err    = 1'b0;
        w_ovf_err   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_hs) begin
                    w_len_nxt = LEN_ONE;
                    if (s_last) begin
                        w_complete = 1'b1;
                        w_cpl_len  = LEN_ONE;
                        w_cpl_id   = s_id;
                    end else begin
                        w_state_nxt = ST_IN_FRAME;
                    end
                end
            end
            ST_IN_FRAME: begin
                if (w_hs) begin
                    w_len_nxt = w_len_inc;
                    w_ovf_err = (r_len == LEN_MAX);
                    w_id_err  = (s_id != r_id_cap);
                    if (s_last) begin
                        w_complete  = 1'b1;
                        w_cpl_len   = w_len_inc;
                        w_cpl_id    = r_id_cap;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // r_chk_en stays low for the first edge after reset so a stale stall is never judged.
    assign w_stall_chk    = r_chk_en & r_stall;
    assign w_vld_drop_err = w_stall_chk & ~s_valid;
    assign w_stable_err   = w_stall_chk & s_valid &
                            ((s_id != r_snap_id) | (s_data != r_snap_data) |
                             (s_user != r_snap_user) | (s_last != r_snap_last));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_lfsr         <= LFSR_SEED;
            r_per_cnt      <= 8'd0;
            r_ready        <= 1'b0;
            r_len          <= '0;
            r_id_cap       <= '0;
            r_done         <= 1'b0;
            r_frame_len    <= '0;
            r_frame_id     <= '0;
            r_frame_user   <= '0;
            r_frame_cnt    <= 32'd0;
            r_beat_cnt     <= 32'd0;
            r_chk_en       <= 1'b0;
            r_stall        <= 1'b0;
            r_snap_id      <= '0;
            r_snap_data    <= '0;
            r_snap_user    <= '0;
            r_snap_last    <= 1'b0;
            r_err_vld_drop <= 1'b0;
            r_err_stable   <= 1'b0;
            r_err_id       <= 1'b0;
            r_err_len_ovf  <= 1'b0;
        end else begin
            r_lfsr    <= {r_lfsr[14:0], w_lfsr_fb};
            r_per_cnt <= w_per_nxt;
            r_ready   <= w_ready_nxt;
            if (w_hs) begin
                r_len <= w_len_nxt;
                if (r_state == ST_IDLE) begin
                    r_id_cap <= s_id;
                end
            end
            r_done <= w_complete;
            if (w_complete) begin
                r_frame_len  <= w_cpl_len;
                r_frame_id   <= w_cpl_id;
                r_frame_user <= s_user;
            end
            r_frame_cnt <= r_frame_cnt + 32'(w_complete);
            r_beat_cnt  <= r_beat_cnt + 32'(w_hs);
            r_chk_en    <= 1'b1;
            r_stall     <= s_valid & ~r_ready;
            r_snap_id   <= s_id;
            r_snap_data <= s_data;
            r_snap_user <= s_user;
            r_snap_last <= s_last;
            // A fresh error in the clearing cycle wins over err_clr.
            r_err_vld_drop <= (r_err_vld_drop & ~err_clr) | w_vld_drop_err;
            r_err_stable   <= (r_err_stable & ~err_clr) | w_stable_err;
            r_err_id       <= (r_err_id & ~err_clr) | w_id_err;
            r_err_len_ovf  <= (r_err_len_ovf & ~err_clr) | w_ovf_err;
        end
    end

`ifdef AXIS_RX_SINK_CHECKSUM_EN
    logic [T_DATA_WIDTH-1:0] r_acc;
    logic [T_DATA_WIDTH-1:0] r_frame_xsum;
    logic [T_DATA_WIDTH-1:0] w_acc_nxt;

    assign w_acc_nxt = (r_state == ST_IDLE) ? s_data : (r_acc ^ s_data);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc        <= '0;
            r_frame_xsum <= '0;
        end else begin
            if (w_hs) begin
                r_acc <= w_acc_nxt;
            end
            if (w_complete) begin
                r_frame_xsum <= w_acc_nxt;
            end
        end
    end

    assign frame_xsum = r_frame_xsum;
`endif

    assign s_ready      = r_ready;
    assign frame_done   = r_done;
    assign frame_len    = r_frame_len;
    assign frame_id     = r_frame_id;
    assign frame_user   = r_frame_user;
    assign frame_cnt    = r_frame_cnt;
    assign beat_cnt     = r_beat_cnt;
    assign err_vld_drop = r_err_vld_drop;
    assign err_stable   = r_err_stable;
    assign err_id       = r_err_id;
    assign err_len_ovf  = r_err_len_ovf;
    assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_axis_rx_sink.sv
// Bench for axis_rx_sink: directed table, multi-cycle corner sequences and a randomized run against a frame-level model.
// Built with LEN_WIDTH=4 so length saturation is reachable; AXIS_RX_SINK_CHECKSUM_EN also checks frame_xsum.

module tb_axis_rx_sink;

    localparam int LW      = 4;
    localparam int LEN_MAX = 15;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [7:0]  s_id = 8'd0;
    logic [7:0]  s_data = 8'd0;
    logic [7:0]  s_user = 8'd0;
    logic        s_last = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [1:0]  bp_mode = 2'd0;
    logic [7:0]  bp_period = 8'd0;
    logic        frame_done;
    logic [LW-1:0] frame_len;
    logic [7:0]  frame_id;
    logic [7:0]  frame_user;
    logic [31:0] frame_cnt;
    logic [31:0] beat_cnt;
    logic        err_vld_drop;
    logic        err_stable;
    logic        err_id;
    logic        err_len_ovf;
    logic        err_clr = 1'b0;
    logic        o_dbg_state;
`ifdef AXIS_RX_SINK_CHECKSUM_EN
    logic [7:0]  frame_xsum;
`endif

    axis_rx_sink #(.LEN_WIDTH(LW)) u_dut (
        .clk(clk), .reset_n(reset_n),
        .s_id(s_id), .s_data(s_data), .s_user(s_user), .s_last(s_last),
        .s_valid(s_valid), .s_ready(s_ready),
        .bp_mode(bp_mode), .bp_period(bp_period),
        .frame_done(frame_done), .frame_len(frame_len), .frame_id(frame_id),
        .frame_user(frame_user),
`ifdef AXIS_RX_SINK_CHECKSUM_EN
        .frame_xsum(frame_xsum),
`endif
        .frame_cnt(frame_cnt), .beat_cnt(beat_cnt),
        .err_vld_drop(err_vld_drop), .err_stable(err_stable),
        .err_id(err_id), .err_len_ovf(err_len_ovf),
        .err_clr(err_clr), .o_dbg_state(o_dbg_state)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: beats of the open frame are kept in queues; results derived at the last beat.
    logic [15:0]   m_lfsr;
    logic          m_ready;
    int            m_per;
    logic [7:0]    q_id[$];
    logic [7:0]    q_data[$];
    logic [LW-1:0] exp_q[$];
    logic          e_done;
    logic [LW-1:0] e_len;
    logic [7:0]    e_id;
    logic [7:0]    e_user;
    logic [31:0]   e_fcnt;
    logic [31:0]   e_bcnt;
    logic          e_vd, e_st, e_idm, e_ovf;
    logic          p_stall;
    logic [24:0]   p_fields;
`ifdef AXIS_RX_SINK_CHECKSUM_EN
    logic [7:0]    e_xsum;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_lfsr = 16'hACE1; m_ready = 1'b0; m_per = 0;
        q_id.delete(); q_data.delete(); exp_q.delete();
        e_done = 1'b0; e_len = '0; e_id = 8'd0; e_user = 8'd0;
        e_fcnt = 32'd0; e_bcnt = 32'd0;
        e_vd = 1'b0; e_st = 1'b0; e_idm = 1'b0; e_ovf = 1'b0;
        p_stall = 1'b0; p_fields = '0;
`ifdef AXIS_RX_SINK_CHECKSUM_EN
        e_xsum = 8'd0;
`endif
    endtask

    task automatic model_step();
        logic hs, vd, st, idm, ov, nrdy;
        logic [24:0] fields;
        fields = {s_id, s_data, s_user, s_last};
        hs  = s_valid & m_ready;
        vd  = p_stall & ~s_valid;
        st  = p_stall & s_valid & (fields != p_fields);
        idm = 1'b0; ov = 1'b0;
        e_done = 1'b0;
        if (hs) begin
            q_id.push_back(s_id);
            q_data.push_back(s_data);
            if (q_id.size() > 1 && s_id != q_id[0]) idm = 1'b1;
            if (q_id.size() > LEN_MAX) ov = 1'b1;
            e_bcnt = e_bcnt + 32'd1;
            if (s_last) begin
                e_done = 1'b1;
                e_len  = (q_id.size() > LEN_MAX) ? LW'(LEN_MAX) : LW'(q_id.size());
                e_id   = q_id[0];
                e_user = s_user;
`ifdef AXIS_RX_SINK_CHECKSUM_EN
                e_xsum = 8'd0;
                foreach (q_data[k]) e_xsum ^= q_data[k];
`endif
                e_fcnt = e_fcnt + 32'd1;
                exp_q.push_back(e_len);
                q_id.delete(); q_data.delete();
            end
        end
        e_vd  = (e_vd & ~err_clr) | vd;
        e_st  = (e_st & ~err_clr) | st;
        e_idm = (e_idm & ~err_clr) | idm;
        e_ovf = (e_ovf & ~err_clr) | ov;
        p_stall  = s_valid & ~m_ready;
        p_fields = fields;
        case (bp_mode)
            2'd0: nrdy = 1'b1;
            2'd1: nrdy = m_lfsr[0] | m_lfsr[1];
            2'd2: nrdy = 1'b0;
            default: nrdy = (m_per == int'(bp_period));
        endcase
        if (bp_mode == 2'd3 && m_per != int'(bp_period)) m_per = m_per + 1;
        else m_per = 0;
        m_lfsr  = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        m_ready = nrdy;
    endtask

    task automatic check_all();
        check("s_ready", 32'(s_ready), 32'(m_ready));
        check("frame_done", 32'(frame_done), 32'(e_done));
        check("frame_len", 32'(frame_len), 32'(e_len));
        check("frame_id", 32'(frame_id), 32'(e_id));
        check("frame_user", 32'(frame_user), 32'(e_user));
        check("frame_cnt", frame_cnt, e_fcnt);
        check("beat_cnt", beat_cnt, e_bcnt);
        check("err_vld_drop", 32'(err_vld_drop), 32'(e_vd));
        check("err_stable", 32'(err_stable), 32'(e_st));
        check("err_id", 32'(err_id), 32'(e_idm));
        check("err_len_ovf", 32'(err_len_ovf), 32'(e_ovf));
        check("dbg_state", 32'(o_dbg_state), 32'(q_id.size() != 0));
`ifdef AXIS_RX_SINK_CHECKSUM_EN
        check("frame_xsum", 32'(frame_xsum), 32'(e_xsum));
`endif
        if (frame_done) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_done", 32'(frame_done), 32'd0);
            end else begin
                check("sb_frame_len", 32'(frame_len), 32'(exp_q.pop_front()));
            end
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_reset();
        #1;
        check_all();
        repeat (2) @(negedge clk);
        s_valid = 1'b0;
        err_clr = 1'b0;
        reset_n = 1'b1;
    endtask

    typedef struct {
        logic        valid;
        logic        last;
        logic [7:0]  id;
        logic [7:0]  data;
        logic [7:0]  user;
        logic        e_ready;
        logic        e_done;
        logic [3:0]  e_len;
        logic [7:0]  e_id;
        logic [31:0] e_fcnt;
        logic [31:0] e_bcnt;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int n;
        int beat;
        int ones;
        int rem;
        logic hs_now;
        logic [7:0] fid;

        tbl[0] = '{1'b0, 1'b0, 8'd0, 8'd0, 8'h00, 1'b1, 1'b0, 4'd0, 8'd0, 32'd0, 32'd0};
        tbl[1] = '{1'b1, 1'b0, 8'd3, 8'd1, 8'h10, 1'b1, 1'b0, 4'd0, 8'd0, 32'd0, 32'd1};
        tbl[2] = '{1'b1, 1'b0, 8'd3, 8'd2, 8'h11, 1'b1, 1'b0, 4'd0, 8'd0, 32'd0, 32'd2};
        tbl[3] = '{1'b1, 1'b0, 8'd3, 8'd3, 8'h12, 1'b1, 1'b0, 4'd0, 8'd0, 32'd0, 32'd3};
        tbl[4] = '{1'b1, 1'b1, 8'd3, 8'd4, 8'h13, 1'b1, 1'b1, 4'd4, 8'd3, 32'd1, 32'd4};
        tbl[5] = '{1'b0, 1'b0, 8'd0, 8'd0, 8'h00, 1'b1, 1'b0, 4'd4, 8'd3, 32'd1, 32'd4};

        #2;
        do_reset();
        check("rst_s_ready", 32'(s_ready), 32'd0);
        check("rst_frame_cnt", frame_cnt, 32'd0);

        // 4-beat frame, always ready
        bp_mode = 2'd0;
        for (int i = 0; i < 6; i++) begin
            s_valid = tbl[i].valid; s_last = tbl[i].last; s_id = tbl[i].id;
            s_data = tbl[i].data; s_user = tbl[i].user;
            cycle();
            check("tbl_ready", 32'(s_ready), 32'(tbl[i].e_ready));
            check("tbl_done", 32'(frame_done), 32'(tbl[i].e_done));
            check("tbl_len", 32'(frame_len), 32'(tbl[i].e_len));
            check("tbl_id", 32'(frame_id), 32'(tbl[i].e_id));
            check("tbl_fcnt", frame_cnt, tbl[i].e_fcnt);
            check("tbl_bcnt", beat_cnt, tbl[i].e_bcnt);
`ifdef AXIS_RX_SINK_CHECKSUM_EN
            if (tbl[i].e_done) check("tbl_xsum", 32'(frame_xsum), 32'd4);
`endif
        end
        check("tbl_no_err", 32'({err_vld_drop, err_stable, err_id, err_len_ovf}), 32'd0);

        // Valid dropped while stalled
        bp_mode = 2'd2; s_valid = 1'b0;
        cycle();
        check("m2_ready_low", 32'(s_ready), 32'd0);
        s_valid = 1'b1; s_data = 8'h5A; s_id = 8'd7; s_user = 8'd0; s_last = 1'b1;
        cycle(); cycle();
        s_valid = 1'b0;
        cycle();
        check("vd_set", 32'(err_vld_drop), 32'd1);
        check("vd_stable_clear", 32'(err_stable), 32'd0);
        cycle();
        check("vd_sticky", 32'(err_vld_drop), 32'd1);
        err_clr = 1'b1;
        cycle();
        err_clr = 1'b0;
        check("vd_cleared", 32'(err_vld_drop), 32'd0);

        // Payload changed while stalled
        s_valid = 1'b1; s_data = 8'h5A;
        cycle();
        s_data = 8'h5B;
        cycle();
        check("st_set", 32'(err_stable), 32'd1);
        check("st_no_vd", 32'(err_vld_drop), 32'd0);
        bp_mode = 2'd0;
        cycle(); cycle();
        check("st_release_done", 32'(frame_done), 32'd1);
        check("st_release_len", 32'(frame_len), 32'd1);
        check("st_release_fcnt", frame_cnt, 32'd2);
        s_valid = 1'b0;
        cycle();
        err_clr = 1'b1;
        cycle();
        err_clr = 1'b0;
        check("st_cleared", 32'(err_stable), 32'd0);

        // Periodic backpressure, 8-beat frame
        bp_mode = 2'd3; bp_period = 8'd3; s_id = 8'd5; s_user = 8'h44;
        beat = 0; n = 0; ones = 0;
        while (beat < 8 && n < 60) begin
            s_valid = 1'b1; s_data = 8'(beat); s_last = (beat == 7);
            hs_now = m_ready;
            cycle();
            n++;
            if (s_ready) ones++;
            if (hs_now) beat++;
        end
        check("m3_beats", 32'(beat), 32'd8);
        check("m3_cycles_ok", 32'(n >= 28 && n <= 36), 32'd1);
        check("m3_done", 32'(frame_done), 32'd1);
        check("m3_len", 32'(frame_len), 32'd8);
        check("m3_ready_density", 32'(ones >= n / 4 - 1 && ones <= n / 4 + 1), 32'd1);
        s_valid = 1'b0;

        // id change inside a frame
        bp_mode = 2'd0;
        cycle();
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'b1; s_id = (i == 2) ? 8'd2 : 8'd1; s_last = (i == 2); s_data = 8'(i + 16);
            cycle();
        end
        check("id_err", 32'(err_id), 32'd1);
        check("id_frame_id", 32'(frame_id), 32'd1);
        check("id_len", 32'(frame_len), 32'd3);
        check("id_done", 32'(frame_done), 32'd1);
        s_valid = 1'b0; err_clr = 1'b1;
        cycle();
        err_clr = 1'b0;

        // Length saturation, then reset in the middle of the next frame
        for (int i = 0; i < 20; i++) begin
            s_valid = 1'b1; s_id = 8'd9; s_last = (i == 19); s_data = 8'(i);
            cycle();
        end
        check("ovf_len", 32'(frame_len), 32'd15);
        check("ovf_err", 32'(err_len_ovf), 32'd1);
        s_last = 1'b0;
        cycle(); cycle();
        reset_n = 1'b0;
        #1;
        check("mrst_ready", 32'(s_ready), 32'd0);
        check("mrst_fcnt", frame_cnt, 32'd0);
        check("mrst_bcnt", beat_cnt, 32'd0);
        check("mrst_ovf", 32'(err_len_ovf), 32'd0);
        check("mrst_len", 32'(frame_len), 32'd0);
        check("mrst_state", 32'(o_dbg_state), 32'd0);
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("mrst_no_done", 32'(frame_done), 32'd0);
        end

        // Randomized traffic with occasional master violations
        rem = 0; fid = 8'd0; hs_now = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) begin
                do_reset();
                rem = 0; hs_now = 1'b0;
            end
            if ($urandom_range(0, 149) == 0) begin
                bp_mode = 2'($urandom_range(0, 3));
                bp_period = 8'($urandom_range(0, 5));
            end
            err_clr = ($urandom_range(0, 63) == 0);
            if (s_valid && !hs_now) begin
                if ($urandom_range(0, 49) == 0) s_valid = 1'b0;
                else if ($urandom_range(0, 49) == 0) s_data = 8'($urandom);
            end else begin
                if (rem == 0) begin
                    rem = $urandom_range(1, 20);
                    fid = 8'($urandom);
                end
                s_valid = ($urandom_range(0, 3) != 0);
                s_id = ($urandom_range(0, 19) == 0) ? 8'($urandom) : fid;
                s_data = 8'($urandom);
                s_user = 8'($urandom);
                s_last = (rem == 1);
            end
            hs_now = s_valid & m_ready;
            if (hs_now) rem--;
            cycle();
        end
        err_clr = 1'b0;
        check("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
